// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (signed/unsigned) for the EX-stage DIV/DIVU path.
// One op accepted via valid/ready; quotient/remainder appear WIDTH+1 edges after accept.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic             div_cancel,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             div_done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dq_q, dq_d;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;      // |divisor|
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;

  logic             accept;
  logic [WIDTH-1:0] x_abs, y_abs;
  logic [WIDTH:0]   rem_shift;
  logic             qbit;

  assign div_ready = (state_q == IDLE);
  assign accept    = div_valid && (state_q == IDLE) && !div_cancel;

  assign x_abs = (div_signed && x[WIDTH-1]) ? -x : x;
  assign y_abs = (div_signed && y[WIDTH-1]) ? -y : y;

  // The shifted remainder needs WIDTH+1 bits: |x| = 2^(WIDTH-1) and large unsigned
  // divisors can push it past WIDTH bits before the compare.
  assign rem_shift = {rem_q, dq_q[WIDTH-1]};
  assign qbit      = (rem_shift >= {1'b0, dvs_q});

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    dq_d      = dq_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    s_d       = s_q;
    r_d       = r_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dq_d      = x_abs;
          dvs_d     = y_abs;
          neg_quo_d = div_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
          neg_rem_d = div_signed && x[WIDTH-1];
          div0_d    = (y == '0);
          rem_d     = '0;
          count_d   = '0;
          state_d   = CALC;
        end
      end

      CALC: begin
        if (div_cancel) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          rem_d = WIDTH'(qbit ? (rem_shift - {1'b0, dvs_q}) : rem_shift);
          dq_d  = {dq_q[WIDTH-2:0], qbit};
          if (count_q == CW'(WIDTH - 1)) begin
            count_d = '0;
            state_d = FIX;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end

      FIX: begin
        state_d = IDLE;
        count_d = '0;
        // With a zero divisor every step subtracts nothing, so rem ends as |x| and
        // re-applying the dividend sign returns x unchanged; only s needs an override.
        if (!div_cancel) begin
          s_d    = div0_q ? '1 : (neg_quo_q ? -dq_q : dq_q);
          r_d    = neg_rem_q ? -rem_q : rem_q;
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      dq_q      <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      s_q       <= '0;
      r_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dq_q      <= dq_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      s_q       <= s_d;
      r_q       <= r_d;
      done_q    <= done_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign div_done = done_q;

endmodule
